// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle phase sequencer for the 4-bit-opcode CPU: steps FETCH/DECODE/EXEC/MEM/WB and
// decides when IR load, PC update, memory requests and register writes take effect.
module cpu_phase_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16,
  parameter logic [3:0]  HALT_OP     = 4'b1111
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             func1,
  input  logic             branchTaken,
  input  logic             imemReady,
  input  logic             dmemReady,
  output logic             imemReq,
  output logic             irLoad,
  output logic             dmemReq,
  output logic             dmemWe,
  output logic             regWriteEn,
  output logic             pcWrite,
  output logic [1:0]       pcSrc,
  output logic [2:0]       phase,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    PhIdle   = 3'd0,
    PhFetch  = 3'd1,
    PhDecode = 3'd2,
    PhExec   = 3'd3,
    PhMem    = 3'd4,
    PhWb     = 3'd5,
    PhHalt   = 3'd6
  } phase_t;

  phase_t        state;
  logic [TW-1:0] waitCnt;

  logic isMemOp, isStore, isBranch, isJump, isNop;
  logic waiting, timeoutHit, retire;

  always_comb begin
    isMemOp  = (opcode == 4'b0001) || ((opcode == 4'b0010) && func1);
    isStore  = ((opcode == 4'b0001) || (opcode == 4'b0010)) && func1;
    isBranch = (opcode >= 4'b1001) && (opcode <= 4'b1011);
    isJump   = (opcode == 4'b1100) || (opcode == 4'b1101);
    isNop    = (opcode == 4'b0000);
  end

  // waitCnt holds the number of earlier waiting cycles, so the limit trips on the
  // MEM_TIMEOUT-th consecutive cycle without ready.
  always_comb begin
    waiting    = ((state == PhFetch) && !imemReady) || ((state == PhMem) && !dmemReady);
    timeoutHit = (MEM_TIMEOUT != 0) && waiting && (waitCnt == TW'(MEM_TIMEOUT - 1));
  end

  always_comb begin
    imemReq    = 1'b0;
    irLoad     = 1'b0;
    dmemReq    = 1'b0;
    dmemWe     = 1'b0;
    regWriteEn = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = 2'b00;
    retire     = 1'b0;
    case (state)
      PhFetch: begin
        imemReq = 1'b1;
        irLoad  = imemReady;
      end
      PhExec: begin
        if (isBranch) begin
          pcWrite = 1'b1;
          pcSrc   = branchTaken ? 2'b01 : 2'b00;
          retire  = 1'b1;
        end else if (isJump) begin
          pcWrite = 1'b1;
          pcSrc   = 2'b10;
          retire  = 1'b1;
        end else if (isNop) begin
          pcWrite = 1'b1;
          retire  = 1'b1;
        end
      end
      PhMem: begin
        dmemReq = 1'b1;
        dmemWe  = isStore;
        if (dmemReady && isStore) begin
          pcWrite = 1'b1;
          retire  = 1'b1;
        end
      end
      PhWb: begin
        regWriteEn = 1'b1;
        pcWrite    = 1'b1;
        retire     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= PhIdle;
      waitCnt <= '0;
      fault   <= 1'b0;
      retired <= '0;
    end else begin
      case (state)
        PhIdle: begin
          if (run) begin
            state   <= PhFetch;
            waitCnt <= '0;
          end
        end
        PhFetch: begin
          if (imemReady) begin
            state <= PhDecode;
          end else if (timeoutHit) begin
            fault <= 1'b1;
            state <= PhHalt;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        PhDecode: state <= (opcode == HALT_OP) ? PhHalt : PhExec;
        PhExec: begin
          if (isMemOp) begin
            state   <= PhMem;
            waitCnt <= '0;
          end else if (!(isBranch || isJump || isNop)) begin
            state <= PhWb;
          end
        end
        PhMem: begin
          if (dmemReady) begin
            if (!isStore) state <= PhWb;
          end else if (timeoutHit) begin
            fault <= 1'b1;
            state <= PhHalt;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        PhHalt: ;
        default: state <= PhIdle;
      endcase
      // Retirement overrides the per-phase next state.
      if (retire) begin
        retired <= retired + 1'b1;
        state   <= run ? PhFetch : PhIdle;
        waitCnt <= '0;
      end
    end
  end

  assign phase  = state;
  assign busy   = (state != PhIdle) && (state != PhHalt);
  assign halted = (state == PhHalt);

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed bench for cpu_phase_sequencer: per-cycle phase/strobe expectations go through a
// scoreboard queue; a narrow-counter second instance exercises retired-count wrap.
module tb_cpu_phase_sequencer;

  logic        clock = 1'b0;
  logic        reset, run, func1, branchTaken, imemReady, dmemReady;
  logic [3:0]  opcode;
  logic        imemReq, irLoad, dmemReq, dmemWe, regWriteEn, pcWrite;
  logic [1:0]  pcSrc;
  logic [2:0]  phase;
  logic        busy, halted, fault;
  logic [15:0] retired;

  logic        imemReq2, irLoad2, dmemReq2, dmemWe2, regWriteEn2, pcWrite2;
  logic [1:0]  pcSrc2;
  logic [2:0]  phase2;
  logic        busy2, halted2, fault2;
  logic [1:0]  retired2;

  int checks = 0;
  int failures = 0;
  int step = 0;
  int expRet = 0;
  logic [10:0] expQ[$];

  // Strobe vector: {imemReq, irLoad, dmemReq, dmemWe, regWriteEn, pcWrite, pcSrc}
  localparam logic [7:0] SN   = 8'h00;
  localparam logic [7:0] SFR  = 8'h80;
  localparam logic [7:0] SFL  = 8'hC0;
  localparam logic [7:0] SMR  = 8'h20;
  localparam logic [7:0] SMW  = 8'h30;
  localparam logic [7:0] SMWD = 8'h34;
  localparam logic [7:0] SWB  = 8'h0C;
  localparam logic [7:0] SPC0 = 8'h04;
  localparam logic [7:0] SBT  = 8'h05;
  localparam logic [7:0] SJ   = 8'h06;

  always #5 clock = ~clock;

  cpu_phase_sequencer #(.MEM_TIMEOUT(16), .CNT_W(16), .HALT_OP(4'b1111)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .func1(func1),
    .branchTaken(branchTaken), .imemReady(imemReady), .dmemReady(dmemReady),
    .imemReq(imemReq), .irLoad(irLoad), .dmemReq(dmemReq), .dmemWe(dmemWe),
    .regWriteEn(regWriteEn), .pcWrite(pcWrite), .pcSrc(pcSrc), .phase(phase),
    .busy(busy), .halted(halted), .fault(fault), .retired(retired)
  );

  cpu_phase_sequencer #(.MEM_TIMEOUT(16), .CNT_W(2), .HALT_OP(4'b1111)) dutNarrow (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode), .func1(func1),
    .branchTaken(branchTaken), .imemReady(imemReady), .dmemReady(dmemReady),
    .imemReq(imemReq2), .irLoad(irLoad2), .dmemReq(dmemReq2), .dmemWe(dmemWe2),
    .regWriteEn(regWriteEn2), .pcWrite(pcWrite2), .pcSrc(pcSrc2), .phase(phase2),
    .busy(busy2), .halted(halted2), .fault(fault2), .retired(retired2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue the expectation, compare at the falling edge.
  task automatic cyc(input logic imr, input logic dmr, input logic bt,
                     input logic [2:0] eph, input logic [7:0] est);
    logic [10:0] got, exp;
    imemReady   = imr;
    dmemReady   = dmr;
    branchTaken = bt;
    expQ.push_back({eph, est});
    @(negedge clock);
    step++;
    got = {phase, imemReq, irLoad, dmemReq, dmemWe, regWriteEn, pcWrite, pcSrc};
    exp = expQ.pop_front();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL step%0d phase/strobes observed=%h expected=%h", step, got, exp);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic fetchImm();
    cyc(1'b1, 1'b0, 1'b0, 3'd1, SFL);
    cyc(1'b0, 1'b0, 1'b0, 3'd2, SN);
  endtask

  task automatic chkRet(input int n);
    logic [31:0] e;
    e = n;
    chk("retired", {16'h0, retired}, {16'h0, e[15:0]});
    chk("retired_wrap", {30'h0, retired2}, {30'h0, e[1:0]});
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; opcode = 4'h0; func1 = 1'b0;
    branchTaken = 1'b0; imemReady = 1'b0; dmemReady = 1'b0;
    @(posedge clock);
    #1;
    cyc(1'b1, 1'b1, 1'b1, 3'd0, SN);
    chkRet(0);
    chk("reset_fault", {31'h0, fault}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_halted", {31'h0, halted}, 32'h0);
    reset = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 3'd0, SN);
    run = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 3'd0, SN);

    // ALU op through WB
    opcode = 4'b0011; func1 = 1'b0;
    fetchImm();
    cyc(1'b0, 1'b0, 1'b0, 3'd3, SN);
    chk("exec_busy", {31'h0, busy}, 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 3'd5, SWB);
    chkRet(++expRet);

    // Load with slow fetch and 3-cycle data memory
    opcode = 4'b0001; func1 = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 3'd1, SFR);
    fetchImm();
    cyc(1'b0, 1'b0, 1'b0, 3'd3, SN);
    cyc(1'b0, 1'b0, 1'b0, 3'd4, SMR);
    cyc(1'b0, 1'b0, 1'b0, 3'd4, SMR);
    cyc(1'b0, 1'b1, 1'b0, 3'd4, SMR);
    cyc(1'b0, 1'b0, 1'b0, 3'd5, SWB);
    chkRet(++expRet);

    // Stores retire from MEM
    func1 = 1'b1;
    fetchImm();
    cyc(1'b0, 1'b0, 1'b0, 3'd3, SN);
    cyc(1'b0, 1'b1, 1'b0, 3'd4, SMWD);
    chkRet(++expRet);
    opcode = 4'b0010;
    fetchImm();
    cyc(1'b0, 1'b0, 1'b0, 3'd3, SN);
    cyc(1'b0, 1'b0, 1'b0, 3'd4, SMW);
    cyc(1'b0, 1'b1, 1'b0, 3'd4, SMWD);
    chkRet(++expRet);
    func1 = 1'b0;
    fetchImm();
    cyc(1'b0, 1'b0, 1'b0, 3'd3, SN);
    cyc(1'b0, 1'b0, 1'b0, 3'd5, SWB);
    chkRet(++expRet);

    // Branches, jump, NOP, 1110
    opcode = 4'b1001;
    fetchImm();
    cyc(1'b0, 1'b0, 1'b1, 3'd3, SBT);
    chkRet(++expRet);
    opcode = 4'b1011;
    fetchImm();
    cyc(1'b0, 1'b0, 1'b0, 3'd3, SPC0);
    chkRet(++expRet);
    opcode = 4'b1100;
    fetchImm();
    cyc(1'b0, 1'b0, 1'b1, 3'd3, SJ);
    chkRet(++expRet);
    opcode = 4'b0000;
    fetchImm();
    cyc(1'b0, 1'b0, 1'b0, 3'd3, SPC0);
    chkRet(++expRet);
    opcode = 4'b1110;
    fetchImm();
    cyc(1'b0, 1'b0, 1'b0, 3'd3, SN);
    cyc(1'b0, 1'b0, 1'b0, 3'd5, SWB);
    chkRet(++expRet);

    // run=0 at retire parks in IDLE
    opcode = 4'b1000;
    fetchImm();
    cyc(1'b0, 1'b0, 1'b0, 3'd3, SN);
    run = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 3'd5, SWB);
    chkRet(++expRet);
    cyc(1'b1, 1'b1, 1'b1, 3'd0, SN);
    chk("idle_busy", {31'h0, busy}, 32'h0);
    run = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 3'd0, SN);

    // Fetch ready on the 16th cycle: no fault
    opcode = 4'b0000;
    repeat (15) cyc(1'b0, 1'b0, 1'b0, 3'd1, SFR);
    fetchImm();
    cyc(1'b0, 1'b0, 1'b0, 3'd3, SPC0);
    chkRet(++expRet);
    chk("no_fault_at_limit", {31'h0, fault}, 32'h0);

    // Reset mid-MEM aborts
    opcode = 4'b0001; func1 = 1'b0;
    fetchImm();
    cyc(1'b0, 1'b0, 1'b0, 3'd3, SN);
    cyc(1'b0, 1'b0, 1'b0, 3'd4, SMR);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 3'd4, SMR);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, SN);
    expRet = 0;
    chkRet(expRet);
    reset = 1'b0;

    // Fetch timeout after 16 cycles
    cyc(1'b0, 1'b0, 1'b0, 3'd0, SN);
    repeat (16) cyc(1'b0, 1'b0, 1'b0, 3'd1, SFR);
    cyc(1'b1, 1'b1, 1'b1, 3'd6, SN);
    chk("fetch_timeout_fault", {31'h0, fault}, 32'h1);
    chk("fetch_timeout_halted", {31'h0, halted}, 32'h1);
    chk("halt_busy", {31'h0, busy}, 32'h0);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 3'd6, SN);
    reset = 1'b0;
    chk("fault_cleared", {31'h0, fault}, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 3'd0, SN);

    // HALT opcode is absorbing and does not retire
    opcode = 4'b0000;
    fetchImm();
    cyc(1'b0, 1'b0, 1'b0, 3'd3, SPC0);
    chkRet(++expRet);
    opcode = 4'b1111;
    fetchImm();
    cyc(1'b1, 1'b1, 1'b0, 3'd6, SN);
    run = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 3'd6, SN);
    run = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 3'd6, SN);
    chkRet(expRet);
    chk("halt_op_halted", {31'h0, halted}, 32'h1);
    chk("halt_op_fault", {31'h0, fault}, 32'h0);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 3'd6, SN);
    reset = 1'b0;
    expRet = 0;
    cyc(1'b0, 1'b0, 1'b0, 3'd0, SN);

    // Data memory timeout on a store
    opcode = 4'b0001; func1 = 1'b1;
    fetchImm();
    cyc(1'b0, 1'b0, 1'b0, 3'd3, SN);
    repeat (16) cyc(1'b0, 1'b0, 1'b0, 3'd4, SMW);
    cyc(1'b0, 1'b1, 1'b0, 3'd6, SN);
    chk("mem_timeout_fault", {31'h0, fault}, 32'h1);
    chkRet(expRet);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
